// File: rtl/aes_sub_shift_serial.sv
// Byte-serial AES (Inv)ShiftRows + (Inv)SubBytes: one shared S-box walks the 16 state bytes,
// reading the shifted source byte and writing output byte k each cycle.

module bSbox (
  input  logic       encrypt,
  input  logic [7:0] a,
  output logic [7:0] q
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] t;
    acc = '0;
    t   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] inv_in;
  logic [7:0] inv_out;

  always_comb begin
    inv_in  = encrypt ? a : aff_inv(a);
    inv_out = gf_inv(inv_in);
    q       = encrypt ? aff_fwd(inv_out) : inv_out;
  end
endmodule

module aes_sub_shift_serial #(
  parameter bit ENC = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   k_q, k_d;
  logic [127:0] src_q, src_d;
  logic [127:0] out_q, out_d;

  logic [7:0]   src_bytes [16];
  logic [1:0]   src_col;
  logic [3:0]   src_idx;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_src_bytes
      assign src_bytes[gi] = src_q[127-8*gi -: 8];
    end
  endgenerate

  // Column wraps in 2 bits; row is unchanged by (Inv)ShiftRows.
  assign src_col = ENC ? (k_q[3:2] + k_q[1:0]) : (k_q[3:2] - k_q[1:0]);
  assign src_idx = {src_col, k_q[1:0]};
  assign sbox_in = src_bytes[src_idx];

  bSbox u_sbox (
    .encrypt (ENC),
    .a       (sbox_in),
    .q       (sbox_out)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    src_d   = src_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          src_d   = in_state;
          k_d     = 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Byte k lives at bit offset 8*(15-k), i.e. {~k, 3'b000}.
        out_d[{~k_q, 3'b000} +: 8] = sbox_out;
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= 4'd0;
      src_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      src_q   <= src_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_state = out_q;
endmodule

// File: tb/tb_aes_sub_shift_serial.sv
// Scoreboard bench for aes_sub_shift_serial: one ENC=0 and one ENC=1 instance, table-based S-box model.

module tb_aes_sub_shift_serial;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_a  [2];
  logic [127:0] in_state_a  [2];
  logic         out_ready_a [2];
  logic         in_ready_a  [2];
  logic         out_valid_a [2];
  logic         busy_a      [2];
  logic [127:0] out_state_a [2];

  always #5 clk = ~clk;

  aes_sub_shift_serial #(.ENC(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a[0]),
    .in_ready  (in_ready_a[0]),
    .in_state  (in_state_a[0]),
    .out_valid (out_valid_a[0]),
    .out_ready (out_ready_a[0]),
    .out_state (out_state_a[0]),
    .busy      (busy_a[0])
  );

  aes_sub_shift_serial #(.ENC(1'b1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a[1]),
    .in_ready  (in_ready_a[1]),
    .in_state  (in_state_a[1]),
    .out_valid (out_valid_a[1]),
    .out_ready (out_ready_a[1]),
    .out_state (out_state_a[1]),
    .busy      (busy_a[1])
  );

  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  bit           tmo;
  int           last_accept;
  logic [127:0] exp_q [$];
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic init_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = x[7:0];
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input int enc);
    logic [127:0] res = '0;
    for (int k = 0; k < 16; k++) begin
      int r = k % 4;
      int c = k / 4;
      int sc = enc ? (c + r) % 4 : (c - r + 4) % 4;
      logic [7:0] b = st[8*(15-(4*sc+r)) +: 8];
      res[8*(15-k) +: 8] = enc ? fwd_tab[b] : inv_tab[b];
    end
    return res;
  endfunction

  function automatic logic [127:0] with_byte(input logic [127:0] st, input int i, input logic [7:0] v);
    st[8*(15-i) +: 8] = v;
    return st;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one state and waits (bounded) for it to be accepted; starts and ends just after a negedge.
  task automatic send(input int sel, input logic [127:0] st, input logic [127:0] exp);
    int n = 0;
    exp_q.push_back(exp);
    in_state_a[sel] = st;
    in_valid_a[sel] = 1'b1;
    while (!in_ready_a[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) tmo = 1'b1;
    last_accept = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[sel] = 1'b0;
  endtask

  task automatic recv(input int sel, output logic [127:0] res, output int lat);
    int n = 0;
    while (!out_valid_a[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) tmo = 1'b1;
    res = out_state_a[sel];
    lat = cyc - last_accept;
    out_ready_a[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_a[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid_a[s]  = 1'b1;
      in_state_a[s]  = rand_state();
      out_ready_a[s] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (out_valid_a[s] !== 1'b0) begin
          failures++;
          $display("FAIL reset_out_valid dut%0d got=%b exp=0", s, out_valid_a[s]);
        end
        checks++;
        if (out_state_a[s] !== 128'h0) begin
          failures++;
          $display("FAIL reset_out_state dut%0d got=%h exp=0", s, out_state_a[s]);
        end
        checks++;
        if (busy_a[s] !== 1'b0) begin
          failures++;
          $display("FAIL reset_busy dut%0d got=%b exp=0", s, busy_a[s]);
        end
        checks++;
        if (in_ready_a[s] !== 1'b0) begin
          failures++;
          $display("FAIL reset_in_ready dut%0d got=%b exp=0", s, in_ready_a[s]);
        end
      end
    end
    rst = 1'b0;
    in_valid_a[0] = 1'b0;
    in_valid_a[1] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (in_ready_a[s] !== 1'b1 || busy_a[s] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release dut%0d in_ready=%b busy=%b exp in_ready=1 busy=0", s, in_ready_a[s], busy_a[s]);
      end
    end
  endtask

  // Directed cases: spec-given stimulus and literal expected results.
  task automatic test_directed();
    logic [127:0] st  [5];
    logic [127:0] ex  [5];
    int           sel [5];
    logic [127:0] res;
    logic [127:0] exp;
    int           lat;
    st[0] = {16{8'h63}};                        ex[0] = 128'h0;                            sel[0] = 0;
    st[1] = 128'h0;                             ex[1] = {16{8'h52}};                       sel[1] = 0;
    st[2] = with_byte({16{8'h63}}, 1, 8'h7c);   ex[2] = with_byte(128'h0, 5, 8'h01);      sel[2] = 0;
    st[3] = with_byte({16{8'h63}}, 13, 8'h7c);  ex[3] = with_byte(128'h0, 1, 8'h01);      sel[3] = 0;
    st[4] = with_byte(128'h0, 5, 8'h01);        ex[4] = with_byte({16{8'h63}}, 1, 8'h7c); sel[4] = 1;
    for (int t = 0; t < 5; t++) begin
      tmo = 1'b0;
      send(sel[t], st[t], ex[t]);
      recv(sel[t], res, lat);
      exp = exp_q.pop_front();
      $display("txn directed%0d dut%0d in=%h out=%h lat=%0d", t, sel[t], st[t], res, lat);
      checks++;
      if (tmo) begin
        failures++;
        $display("FAIL directed%0d_timeout got=timeout exp=handshake", t);
      end
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL directed%0d_data got=%h exp=%h", t, res, exp);
      end
      checks++;
      if (lat != 16) begin
        failures++;
        $display("FAIL directed%0d_latency got=%0d exp=16", t, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] st;
    logic [127:0] res;
    logic [127:0] exp;
    int           lat;
    for (int t = 0; t < 20; t++) begin
      int sel = (t < 16) ? 0 : 1;
      st = rand_state();
      tmo = 1'b0;
      send(sel, st, model(st, sel));
      recv(sel, res, lat);
      exp = exp_q.pop_front();
      $display("txn random%0d dut%0d in=%h out=%h lat=%0d", t, sel, st, res, lat);
      checks++;
      if (tmo || res !== exp) begin
        failures++;
        $display("FAIL random%0d_data got=%h exp=%h timeout=%b", t, res, exp, tmo);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] sta = rand_state();
    logic [127:0] stb = rand_state();
    logic [127:0] expa;
    logic [127:0] res;
    logic [127:0] exp;
    int           n = 0;
    int           lat;
    tmo = 1'b0;
    send(0, sta, model(sta, 0));
    expa = exp_q.pop_front();
    while (!out_valid_a[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL bp_wait_valid got=timeout exp=out_valid");
    end
    in_state_a[0]  = stb;
    in_valid_a[0]  = 1'b1;
    out_ready_a[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_state_a[0] !== expa || out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d out=%h valid=%b in_ready=%b exp out=%h valid=1 in_ready=0",
                 i, out_state_a[0], out_valid_a[0], in_ready_a[0], expa);
      end
    end
    $display("txn bp_held in=%h out=%h", sta, out_state_a[0]);
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    checks++;
    if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle in_ready=%b valid=%b busy=%b exp 1 0 0", in_ready_a[0], out_valid_a[0], busy_a[0]);
    end
    exp_q.push_back(model(stb, 0));
    last_accept = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    checks++;
    if (busy_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept busy=%b in_ready=%b exp busy=1 in_ready=0", busy_a[0], in_ready_a[0]);
    end
    recv(0, res, lat);
    exp = exp_q.pop_front();
    $display("txn bp_next in=%h out=%h lat=%0d", stb, res, lat);
    checks++;
    if (tmo || res !== exp || lat != 16) begin
      failures++;
      $display("FAIL bp_next_data got=%h lat=%0d exp=%h lat=16 timeout=%b", res, lat, exp, tmo);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] sts [3];
    int           acc [$];
    logic [127:0] exp;
    int           got = 0;
    int           idx = 0;
    bit           pend = 1'b0;
    for (int i = 0; i < 3; i++) sts[i] = rand_state();
    out_ready_a[0] = 1'b1;
    in_state_a[0]  = sts[0];
    in_valid_a[0]  = 1'b1;
    for (int n = 0; n < 200 && got < 3; n++) begin
      if (out_valid_a[0]) begin
        exp = exp_q.pop_front();
        $display("txn b2b%0d out=%h lat=%0d", got, out_state_a[0], cyc - acc[got]);
        checks++;
        if (out_state_a[0] !== exp || (cyc - acc[got]) != 16) begin
          failures++;
          $display("FAIL b2b%0d_data got=%h lat=%0d exp=%h lat=16", got, out_state_a[0], cyc - acc[got], exp);
        end
        got++;
      end
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 3) in_state_a[0] = sts[idx];
        else in_valid_a[0] = 1'b0;
      end
      if (in_valid_a[0] && in_ready_a[0]) begin
        exp_q.push_back(model(sts[idx], 0));
        acc.push_back(cyc + 1);
        pend = 1'b1;
      end
      @(negedge clk);
    end
    out_ready_a[0] = 1'b0;
    in_valid_a[0]  = 1'b0;
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", got);
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 18) begin
        failures++;
        $display("FAIL b2b_interval%0d got=%0d exp=18", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] res;
    logic [127:0] exp;
    int           lat;
    tmo = 1'b0;
    send(0, {16{8'h63}}, 128'h0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre in_ready=%b busy=%b exp in_ready=0 busy=1", in_ready_a[0], busy_a[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid_a[0] !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_valid%0d got=%b exp=0", i, out_valid_a[0]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_state_a[0] !== 128'h0 || in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle out=%h in_ready=%b busy=%b exp out=0 in_ready=1 busy=0",
               out_state_a[0], in_ready_a[0], busy_a[0]);
    end
    send(0, {16{8'h63}}, 128'h0);
    recv(0, res, lat);
    exp = exp_q.pop_front();
    $display("txn midrst_resubmit out=%h lat=%0d", res, lat);
    checks++;
    if (tmo || res !== exp || lat != 16) begin
      failures++;
      $display("FAIL midrst_resubmit got=%h lat=%0d exp=%h lat=16 timeout=%b", res, lat, exp, tmo);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid_a[s]  = 1'b0;
      in_state_a[s]  = '0;
      out_ready_a[s] = 1'b0;
    end
    init_tables();
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
